winograd_f23_conv: RTL
======================

Name: winograd_f23_conv

Overview:
- Downstream consumer of the Winograd F(2,3) filter-transform block.
- Latches the four transformed filter values U = G·w (that block's r1..r4) into this block's u1..u4 ports.
- Receives a serial stream of input samples and forms overlapping 4-sample tiles (stride 2).
- Per tile, computes B^T·d, the element-wise product with U, and A^T·m, giving two 1-D correlation outputs per tile.
- Always ready, no backpressure; 3-stage pipeline after tile completion.

Parameters:
- DATA_W, 32, signed width of input samples and U values.
- ACC_W, 64, signed width of products, sums and outputs.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 at a rising edge resets).
- u_load  in  1  load strobe for u1..u4.
- u1  in  DATA_W  transformed filter element 0 (= w1).
- u2  in  DATA_W  transformed filter element 1 (= (w1+w2+w3)/2).
- u3  in  DATA_W  transformed filter element 2 (= (w1-w2+w3)/2).
- u4  in  DATA_W  transformed filter element 3 (= w3).
- in_valid  in  1  in_data valid this cycle; always accepted.
- in_data  in  DATA_W  signed input sample.
- out_valid  out  1  one-cycle pulse per completed tile.
- out_y0  out  ACC_W  first correlation output of the tile.
- out_y1  out  ACC_W  second correlation output of the tile.

Behaviour:
- Reset (rst==0 at an edge):
  - Clears the U registers, the 4-entry sample window, the fill counter, all stage valids and data registers, out_valid, out_y0 and out_y1 (all 0).
  - Reset mid-operation discards in-flight tiles and partial windows.
  - No out_valid is produced from pre-reset samples.
- U registers:
  - u_load=1 at an edge loads u1..u4.
  - A multiply occurring at the same edge uses the pre-load U values.
  - U holds otherwise.
- Window:
  - Accepted sample shifts in as newest: d0<-d1, d1<-d2, d2<-d3, d3<-in_data.
  - in_valid=0: window, counter and stages hold their data; valids still advance (bubbles).
- Tile state machine:
  - FILL: counts 0..3 accepted samples; the 4th accepted sample completes the first tile and moves to STEADY with phase=0.
  - STEADY: phase toggles per accepted sample; each accepted sample making phase 1->0 completes a tile (every 2nd sample).
  - Tile samples are the window contents after the completing shift.
- Pipeline, for a tile completed at edge k:
  - Edge k+1: V = [d0-d2, d1+d2, d2-d1, d1-d3], sign-extended to DATA_W+2.
  - Edge k+2: M[i] = V[i]*U[i], full product sign-extended or truncated to ACC_W.
  - Edge k+3: out_y0 = M0+M1+M2, out_y1 = M1-M2-M3, computed in ACC_W with two's-complement wrap; out_valid=1 for exactly one cycle.
  - Latency is 3 cycles from the accepting edge; sustained throughput is one tile per 2 accepted samples.
- Outputs:
  - out_y0 and out_y1 hold their last value while out_valid=0.
  - Back-to-back tiles are never closer than 2 cycles.
- Arithmetic: U is taken as given (integer). Any halving error from odd w is the upstream block's responsibility.

Decomposition:
- Package winograd_f23_pkg holds:
  - constants TILE_LEN=4, TILE_STEP=2, OUT_PER_TILE=2;
  - FSM state enum {FILL, STEADY};
  - the A^T/B^T coefficient convention as documented constants.
- One natural sub-module: winograd_f23_in_xform, combinational B^T·d with 4 inputs, 4 outputs, DATA_W -> DATA_W+2.

Test Plan:
1. Basic tile: rst low 3 cycles then high; u_load with u=(0,3,1,4) [w=(0,2,4)]; stream d=1,2,3,4 on consecutive cycles -> out_valid pulse 3 cycles after the 4th sample, out_y0=16, out_y1=22.
2. Sliding: continue with 5,6 -> second pulse, out_y0=28, out_y1=34; no pulse after sample 5 alone.
3. Bubbles: same stream as 1-2 with in_valid low every other cycle -> identical values (16/22, 28/34); each pulse 3 cycles after its completing sample.
4. Reload race: assert u_load with u=(1,1,1,1) on the edge where tile 2's multiply occurs -> tile 2 still gives 28/34; tile 3 (samples 7,8; d=5..8) gives y0=d0-d2+d1+d2+d2-d1=5+7=12, y1=(d1+d2)-(d2-d1)-(d1-d3)=6+8=14.
5. Reset mid-stream: rst low for 1 cycle between samples 5 and 6 -> no further pulses until 4 new samples are accepted; all outputs read 0 after reset.
6. Wrap: u=(2^31-1 ×4), d=(2^31-1, -2^31, 2^31-1, -2^31) -> outputs match a 64-bit two's-complement reference model; no X.

Source files
------------

// File: rtl/winograd_f23_pkg.sv
// Shared constants, FSM state type and transform coefficients for the
// Winograd F(2,3) 1-D correlation datapath.
package winograd_f23_pkg;

    localparam int unsigned TILE_LEN     = 4;
    localparam int unsigned TILE_STEP    = 2;
    localparam int unsigned OUT_PER_TILE = 2;

    typedef enum logic {
        FILL,
        STEADY
    } tile_state_t;

    // Row i gives the weights of d0..d3 in V[i] = (B^T d)[i].
    localparam int BT [TILE_LEN][TILE_LEN] = '{
        '{ 1,  0, -1,  0},
        '{ 0,  1,  1,  0},
        '{ 0, -1,  1,  0},
        '{ 0,  1,  0, -1}
    };

    // Row k gives the weights of M0..M3 in y[k] = (A^T m)[k].
    localparam int AT [OUT_PER_TILE][TILE_LEN] = '{
        '{ 1,  1,  1,  0},
        '{ 0,  1, -1, -1}
    };

endpackage

// File: rtl/winograd_f23_in_xform.sv
// Combinational input transform V = B^T * d, widened by two bits so that
// sums and differences of two samples can never overflow.
module winograd_f23_in_xform
    import winograd_f23_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic signed [DATA_W-1:0] i_d0,
    input  logic signed [DATA_W-1:0] i_d1,
    input  logic signed [DATA_W-1:0] i_d2,
    input  logic signed [DATA_W-1:0] i_d3,
    output logic signed [DATA_W+1:0] o_v0,
    output logic signed [DATA_W+1:0] o_v1,
    output logic signed [DATA_W+1:0] o_v2,
    output logic signed [DATA_W+1:0] o_v3
);

    localparam int unsigned XW = DATA_W + 2;

    logic signed [DATA_W-1:0] w_d [TILE_LEN];
    logic signed [XW-1:0]     w_v [TILE_LEN];

    always_comb begin
        w_d[0] = i_d0;
        w_d[1] = i_d1;
        w_d[2] = i_d2;
        w_d[3] = i_d3;
        for (int unsigned i = 0; i < TILE_LEN; i++) begin
            w_v[i] = '0;
            for (int unsigned j = 0; j < TILE_LEN; j++) begin
                case (BT[i][j])
                    1:       w_v[i] = w_v[i] + XW'(w_d[j]);
                    -1:      w_v[i] = w_v[i] - XW'(w_d[j]);
                    default: w_v[i] = w_v[i];
                endcase
            end
        end
    end

    assign o_v0 = w_v[0];
    assign o_v1 = w_v[1];
    assign o_v2 = w_v[2];
    assign o_v3 = w_v[3];

endmodule

// File: rtl/winograd_f23_conv.sv
// Winograd F(2,3) 1-D correlation: stride-2 tiles of 4 samples, pipelined
// B^T d -> element-wise multiply by U -> A^T m, two outputs per tile.
module winograd_f23_conv
    import winograd_f23_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     u_load,
    input  logic signed [DATA_W-1:0] u1,
    input  logic signed [DATA_W-1:0] u2,
    input  logic signed [DATA_W-1:0] u3,
    input  logic signed [DATA_W-1:0] u4,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic signed [ACC_W-1:0]  out_y0,
    output logic signed [ACC_W-1:0]  out_y1
);

    localparam int unsigned XW    = DATA_W + 2;
    localparam int unsigned PW    = XW + DATA_W;
    localparam int unsigned CNT_W = $clog2(TILE_LEN);

    logic signed [DATA_W-1:0] r_u   [TILE_LEN];
    logic signed [DATA_W-1:0] r_win [TILE_LEN];
    tile_state_t              r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_phase;
    logic                     r_tile_v;

    logic signed [XW-1:0]     w_v [TILE_LEN];
    logic signed [XW-1:0]     r_v [TILE_LEN];
    logic                     r_v_valid;
    logic signed [ACC_W-1:0]  r_m [TILE_LEN];
    logic                     r_m_valid;
    logic signed [ACC_W-1:0]  w_y [OUT_PER_TILE];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < TILE_LEN; i++) r_u[i] <= '0;
        end else if (u_load) begin
            r_u[0] <= u1;
            r_u[1] <= u2;
            r_u[2] <= u3;
            r_u[3] <= u4;
        end
    end

    // r_tile_v marks that the window now holds a complete tile.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= FILL;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
            r_tile_v <= 1'b0;
            for (int unsigned i = 0; i < TILE_LEN; i++) r_win[i] <= '0;
        end else begin
            r_tile_v <= 1'b0;
            if (in_valid) begin
                for (int unsigned i = 0; i < TILE_LEN - 1; i++) r_win[i] <= r_win[i+1];
                r_win[TILE_LEN-1] <= in_data;
                case (r_state)
                    FILL: begin
                        if (r_cnt == CNT_W'(TILE_LEN - 1)) begin
                            r_state  <= STEADY;
                            r_cnt    <= '0;
                            r_phase  <= 1'b0;
                            r_tile_v <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    STEADY: begin
                        r_phase  <= ~r_phase;
                        r_tile_v <= (r_phase == 1'(TILE_STEP - 1));
                    end
                    default: r_state <= FILL;
                endcase
            end
        end
    end

    winograd_f23_in_xform #(
        .DATA_W (DATA_W)
    ) u_in_xform (
        .i_d0 (r_win[0]),
        .i_d1 (r_win[1]),
        .i_d2 (r_win[2]),
        .i_d3 (r_win[3]),
        .o_v0 (w_v[0]),
        .o_v1 (w_v[1]),
        .o_v2 (w_v[2]),
        .o_v3 (w_v[3])
    );

    always_comb begin
        for (int unsigned k = 0; k < OUT_PER_TILE; k++) begin
            w_y[k] = '0;
            for (int unsigned i = 0; i < TILE_LEN; i++) begin
                case (AT[k][i])
                    1:       w_y[k] = w_y[k] + r_m[i];
                    -1:      w_y[k] = w_y[k] - r_m[i];
                    default: w_y[k] = w_y[k];
                endcase
            end
        end
    end

    // Stage data loads only with its incoming valid, so bubbles leave it intact.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_v_valid <= 1'b0;
            r_m_valid <= 1'b0;
            out_valid <= 1'b0;
            out_y0    <= '0;
            out_y1    <= '0;
            for (int unsigned i = 0; i < TILE_LEN; i++) begin
                r_v[i] <= '0;
                r_m[i] <= '0;
            end
        end else begin
            r_v_valid <= r_tile_v;
            r_m_valid <= r_v_valid;
            out_valid <= r_m_valid;
            if (r_tile_v) begin
                for (int unsigned i = 0; i < TILE_LEN; i++) r_v[i] <= w_v[i];
            end
            if (r_v_valid) begin
                for (int unsigned i = 0; i < TILE_LEN; i++)
                    r_m[i] <= ACC_W'(PW'(r_v[i]) * PW'(r_u[i]));
            end
            if (r_m_valid) begin
                out_y0 <= w_y[0];
                out_y1 <= w_y[1];
            end
        end
    end

endmodule
